// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART program loader.
package uart_loader_pkg;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
  typedef enum logic [1:0] {L_IDLE, L_LOAD, L_WRITE, L_DONE} ld_state_e;

  localparam logic [31:0] EOP_WORD_DEFAULT = 32'h0000_0FFF;
  localparam int          BYTES_PER_WORD   = 4;

endpackage

// File: rtl/uart_prog_loader_if.sv
// Instruction-memory write port: the loader drives it as master, the ICCM is the slave.
interface uart_prog_loader_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic [3:0]            be;
  logic                  gnt;

  modport master (output req, we, addr, wdata, be, input gnt);
  modport slave  (input req, we, addr, wdata, be, output gnt);
endinterface

// File: rtl/uart_rx_deser.sv
// 8N1 UART receiver: 2-flop synchroniser, start/data/stop FSM, one-cycle byte strobe.
// start_o exists only when UART_LOADER_TIMEOUT_EN is defined.
module uart_rx_deser
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
`ifdef UART_LOADER_TIMEOUT_EN
  output logic       start_o,
`endif
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_e     state_q;
  logic [1:0]    sync_q;
  logic          prev_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          byte_valid_q;
  logic          frame_err_q;

  logic rx_s;
  logic start_edge;

  assign rx_s       = sync_q[1];
  assign start_edge = (state_q == R_IDLE) && prev_q && !rx_s;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      // NOTE: synchroniser resets to the idle-high line level so reset release never looks like a start edge.
      sync_q       <= 2'b11;
      prev_q       <= 1'b1;
      state_q      <= R_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      // NOTE: every state register uses <= so all updates see the pre-edge values.
      sync_q       <= {sync_q[0], rx_i};
      prev_q       <= rx_s;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        R_IDLE: begin
          if (start_edge) begin
            state_q <= R_START;
            cnt_q   <= '0;
          end
        end
        R_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= rx_s ? R_IDLE : R_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        R_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[7:1]};
            bit_q   <= bit_q + 1'b1;
            if (bit_q == 3'd7) state_q <= R_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        R_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q        <= '0;
            byte_valid_q <= rx_s;
            frame_err_q  <= !rx_s;
            state_q      <= R_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= R_IDLE;
      endcase
    end
  end

`ifdef UART_LOADER_TIMEOUT_EN
  assign start_o = start_edge;
`endif
  assign byte_o       = shift_q;
  assign byte_valid_o = byte_valid_q;
  assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/uart_prog_loader.sv
// Boot-time program loader: UART bytes -> little-endian words -> ICCM writes, core held in reset until done.
// Optional idle-line timeout end-of-load enabled by defining UART_LOADER_TIMEOUT_EN.
module uart_prog_loader
  import uart_loader_pkg::*;
#(
  parameter int                    CLKS_PER_BIT = 10417,
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter logic [31:0]           EOP_WORD     = EOP_WORD_DEFAULT
`ifdef UART_LOADER_TIMEOUT_EN
  ,
  parameter int                    TIMEOUT_CLKS = 2000000
`endif
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      sel_i,
  input  logic                      uart_rx_i,
  uart_prog_loader_if.master        wr,
  output logic                      core_rst_no,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_frame_err;

  ld_state_e             ld_state_q;
  logic [1:0]            byte_cnt_q;
  logic [23:0]           asm_q;
  logic                  req_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  core_rst_n_q;
  logic                  err_q;

  logic        accepting;
  logic        word_valid;
  logic [31:0] word_d;

`ifdef UART_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  logic          rx_start;
  logic [TW-1:0] tmo_cnt_q;
  logic          wrote_q;
  logic          timeout;
  assign timeout = wrote_q && (tmo_cnt_q == TW'(TIMEOUT_CLKS));
`endif

  uart_rx_deser #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .rx_i        (uart_rx_i),
`ifdef UART_LOADER_TIMEOUT_EN
    .start_o     (rx_start),
`endif
    .byte_o      (rx_byte),
    .byte_valid_o(rx_valid),
    .frame_err_o (rx_frame_err)
  );

  // Bytes are only taken while a load is active; the 4th byte completes a word.
  assign accepting  = (ld_state_q == L_LOAD) || (ld_state_q == L_WRITE);
  assign word_valid = accepting && rx_valid && (byte_cnt_q == 2'(BYTES_PER_WORD - 1));
  assign word_d     = {rx_byte, asm_q};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ld_state_q   <= L_IDLE;
      byte_cnt_q   <= '0;
      asm_q        <= '0;
      req_q        <= 1'b0;
      addr_q       <= BASE_ADDR;
      wdata_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      core_rst_n_q <= 1'b0;
      err_q        <= 1'b0;
`ifdef UART_LOADER_TIMEOUT_EN
      tmo_cnt_q    <= '0;
      wrote_q      <= 1'b0;
`endif
    end else begin
      if (accepting && rx_valid) begin
        byte_cnt_q <= byte_cnt_q + 1'b1;
        asm_q      <= {rx_byte, asm_q[23:8]};
      end
      if (accepting && rx_frame_err) err_q <= 1'b1;
`ifdef UART_LOADER_TIMEOUT_EN
      if (rx_start)                              tmo_cnt_q <= '0;
      else if (tmo_cnt_q != TW'(TIMEOUT_CLKS))   tmo_cnt_q <= tmo_cnt_q + 1'b1;
`endif
      case (ld_state_q)
        L_IDLE: begin
          if (sel_i) begin
            ld_state_q <= L_LOAD;
            busy_q     <= 1'b1;
          end else begin
            ld_state_q   <= L_DONE;
            done_q       <= 1'b1;
            core_rst_n_q <= 1'b1;
          end
        end
        L_LOAD: begin
          if (word_valid) begin
            if (word_d == EOP_WORD) begin
              ld_state_q   <= L_DONE;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
              core_rst_n_q <= 1'b1;
            end else begin
              wdata_q    <= word_d;
              req_q      <= 1'b1;
              ld_state_q <= L_WRITE;
            end
          end
`ifdef UART_LOADER_TIMEOUT_EN
          else if (timeout) begin
            ld_state_q   <= L_DONE;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            core_rst_n_q <= 1'b1;
            if (byte_cnt_q != 2'd0) err_q <= 1'b1;
          end
`endif
        end
        L_WRITE: begin
          // A word completing while the write is still pending is an overrun and is dropped.
          if (word_valid) err_q <= 1'b1;
          if (wr.gnt) begin
            req_q      <= 1'b0;
            addr_q     <= addr_q + ADDR_WIDTH'(4);
            ld_state_q <= L_LOAD;
`ifdef UART_LOADER_TIMEOUT_EN
            wrote_q    <= 1'b1;
`endif
          end
        end
        L_DONE:  ;
        default: ld_state_q <= L_IDLE;
      endcase
    end
  end

  assign wr.req      = req_q;
  assign wr.we       = req_q;
  assign wr.addr     = addr_q;
  assign wr.wdata    = wdata_q;
  assign wr.be       = 4'hF;
  assign core_rst_no = core_rst_n_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed + randomized bench for uart_prog_loader; expected writes come from a byte-stream model.
module tb_uart_prog_loader;

  localparam int          CPB  = 16;
  localparam int          AW   = 32;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] EOP  = 32'h0000_0FFF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic sel   = 1'b0;
  logic rx    = 1'b1;
  logic core_rst_n, busy, done, err;

  uart_prog_loader_if #(.ADDR_WIDTH(AW)) wr ();

  uart_prog_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_WIDTH  (AW),
    .BASE_ADDR   (BASE),
    .EOP_WORD    (EOP)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .sel_i      (sel),
    .uart_rx_i  (rx),
    .wr         (wr),
    .core_rst_no(core_rst_n),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [63:0] trace_q[$];
  logic [7:0]  bytes_q[$];
  int          req_rises;
  logic        req_prev;

  // Write trace: one entry per accepted handshake, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      trace_q.delete();
      req_rises = 0;
      req_prev  = 1'b0;
    end else begin
      if (wr.req && wr.gnt) trace_q.push_back({wr.addr, wr.wdata});
      if (wr.req && !req_prev) req_rises++;
      req_prev = wr.req;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   64'(wr.req),     64'd0);
    check({tag, "_we"},    64'(wr.we),      64'd0);
    check({tag, "_addr"},  64'(wr.addr),    64'(BASE));
    check({tag, "_wdata"}, 64'(wr.wdata),   64'd0);
    check({tag, "_be"},    64'(wr.be),      64'hF);
    check({tag, "_crst"},  64'(core_rst_n), 64'd0);
    check({tag, "_busy"},  64'(busy),       64'd0);
    check({tag, "_done"},  64'(done),       64'd0);
    check({tag, "_err"},   64'(err),        64'd0);
  endtask

  task automatic do_reset(input logic s);
    rst_n = 1'b0;
    sel   = s;
    rx    = 1'b1;
    bytes_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) tick();
    end
    rx = stop;
    repeat (CPB) tick();
    rx = 1'b1;
    repeat (2 * CPB) tick();
  endtask

  task automatic send_word(input logic [31:0] w, input logic record);
    for (int i = 0; i < 4; i++) begin
      if (record) bytes_q.push_back(w[8*i +: 8]);
      send_byte(w[8*i +: 8], 1'b1);
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == EOP) w = 32'h1234_5678;
    return w;
  endfunction

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
  endtask

  // Reference model: group the good bytes four at a time (first byte is the LSB),
  // stop at the end marker, and place the words at consecutive word addresses.
  task automatic check_trace(input string tag);
    logic [63:0] exp_q[$];
    logic [31:0] w;
    int          n;
    for (int k = 0; k + 3 < bytes_q.size(); k += 4) begin
      w = {bytes_q[k+3], bytes_q[k+2], bytes_q[k+1], bytes_q[k]};
      if (w == EOP) break;
      exp_q.push_back({BASE + 32'(k), w});
    end
    check({tag, "_len"}, 64'(trace_q.size()), 64'(exp_q.size()));
    n = (trace_q.size() < exp_q.size()) ? trace_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_wr%0d", tag, i), trace_q[i], exp_q[i]);
  endtask

  initial begin
    logic [31:0] w, wa, wc;
    logic [31:0] a0, d0;
    logic        stable;
    logic [7:0]  spec_bytes[12];

    wr.gnt = 1'b1;

    // Reset state
    rst_n = 1'b0;
    sel   = 1'b1;
    repeat (2) tick();
    check_reset_outputs("rst");

    // Spec two-word load, grant tied high
    rst_n = 1'b1;
    tick();
    check("load_busy", 64'(busy), 64'd1);
    check("load_done_early", 64'(done), 64'd0);
    spec_bytes = '{8'h13, 8'h01, 8'h20, 8'h00, 8'h93, 8'h02, 8'h40, 8'h00,
                   8'hFF, 8'h0F, 8'h00, 8'h00};
    foreach (spec_bytes[i]) begin
      bytes_q.push_back(spec_bytes[i]);
      send_byte(spec_bytes[i], 1'b1);
    end
    wait_done("load", 50);
    check_trace("load");
    check("load_wr0_fixed", trace_q.size() > 0 ? trace_q[0] : 64'hX, {32'h0, 32'h0020_0113});
    check("load_pulses", 64'(req_rises), 64'd2);
    check("load_crst", 64'(core_rst_n), 64'd1);
    check("load_busy_end", 64'(busy), 64'd0);
    check("load_err", 64'(err), 64'd0);

    // Random multi-word load
    do_reset(1'b1);
    tick();
    for (int i = 0; i < 6; i++) send_word(rand_word(), 1'b1);
    send_word(EOP, 1'b1);
    wait_done("rand", 50);
    check_trace("rand");
    check("rand_addr", 64'(wr.addr), 64'(BASE + 32'd24));
    check("rand_err", 64'(err), 64'd0);

    // Direct boot ignores UART traffic
    do_reset(1'b0);
    repeat (2) tick();
    check("boot_done", 64'(done), 64'd1);
    check("boot_crst", 64'(core_rst_n), 64'd1);
    check("boot_busy", 64'(busy), 64'd0);
    send_word(rand_word(), 1'b0);
    check("boot_pulses", 64'(req_rises), 64'd0);
    check("boot_err", 64'(err), 64'd0);

    // Backpressure: request must hold address and data until granted
    wr.gnt = 1'b0;
    do_reset(1'b1);
    tick();
    w = rand_word();
    send_word(w, 1'b1);
    check("bp_req", 64'(wr.req), 64'd1);
    a0 = wr.addr;
    d0 = wr.wdata;
    stable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!(wr.req && wr.we && wr.addr == a0 && wr.wdata == d0)) stable = 1'b0;
    end
    check("bp_stable", 64'(stable), 64'd1);
    check("bp_addr", 64'(a0), 64'(BASE));
    check("bp_wdata", 64'(d0), 64'(w));
    wr.gnt = 1'b1;
    tick();
    check("bp_req_drop", 64'(wr.req), 64'd0);
    check("bp_addr_inc", 64'(wr.addr), 64'(BASE + 32'd4));
    send_word(EOP, 1'b1);
    wait_done("bp", 50);
    check_trace("bp");

    // Framing error: bad byte is flagged and not counted
    do_reset(1'b1);
    tick();
    send_byte(8'hA5, 1'b0);
    check("fe_err", 64'(err), 64'd1);
    send_word(rand_word(), 1'b1);
    send_word(EOP, 1'b1);
    wait_done("fe", 50);
    check_trace("fe");

    // Glitch: short low pulse is neither a byte nor an error
    do_reset(1'b1);
    tick();
    rx = 1'b0;
    repeat (3) tick();
    rx = 1'b1;
    repeat (40) tick();
    check("gl_err", 64'(err), 64'd0);
    send_word(rand_word(), 1'b1);
    send_word(EOP, 1'b1);
    wait_done("gl", 50);
    check_trace("gl");
    check("gl_err_end", 64'(err), 64'd0);

    // Overrun: second word arrives while the first write is stalled
    wr.gnt = 1'b0;
    do_reset(1'b1);
    tick();
    wa = rand_word();
    send_word(wa, 1'b1);
    send_word(rand_word(), 1'b0);
    check("ov_err", 64'(err), 64'd1);
    check("ov_wdata", 64'(wr.wdata), 64'(wa));
    check("ov_req", 64'(wr.req), 64'd1);
    wr.gnt = 1'b1;
    tick();
    wc = rand_word();
    send_word(wc, 1'b1);
    send_word(EOP, 1'b1);
    wait_done("ov", 50);
    check_trace("ov");

    // Reset mid-byte with a write pending, then a fresh load
    wr.gnt = 1'b0;
    do_reset(1'b1);
    tick();
    send_word(rand_word(), 1'b0);
    check("mr_req", 64'(wr.req), 64'd1);
    rx = 1'b0;
    repeat (40) tick();
    rst_n = 1'b0;
    tick();
    check_reset_outputs("mr");
    rx = 1'b1;
    repeat (2) tick();
    rst_n  = 1'b1;
    wr.gnt = 1'b1;
    tick();
    check("mr_busy", 64'(busy), 64'd1);
    send_word(rand_word(), 1'b1);
    send_word(EOP, 1'b1);
    wait_done("mr", 50);
    check_trace("mr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
